// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch stepping plus jump/branch redirects
// that land a fixed number of clock edges after they are accepted.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          OFF_WIDTH    = 8,
  parameter int unsigned          STEP         = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned          REDIRECT_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 STALL,
  input  logic                 JUMP,
  input  logic                 BEQ,
  input  logic                 BNE,
  input  logic                 ZERO,
  input  logic [OFF_WIDTH-1:0] OFFSET,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PC_SEQ,
  output logic                 FETCH_VALID,
  output logic                 REDIRECT_BUSY
);

  localparam int unsigned SHIFT = $clog2(STEP);
  localparam int unsigned CNT_W = (REDIRECT_LAT > 2) ? $clog2(REDIRECT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((REDIRECT_LAT >= 2) ? (REDIRECT_LAT - 2) : 0);

  typedef enum logic [1:0] {StInit, StRun, StWait} state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] tgt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fetch_valid_q;
  logic                busy_q;

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] target;
  logic                taken;

  // Word offset is sign-extended to full PC width, then scaled to bytes.
  always_comb begin
    pc_seq  = pc_q + PC_WIDTH'(STEP);
    off_ext = PC_WIDTH'($signed(OFFSET));
    target  = pc_seq + (off_ext << SHIFT);
    taken   = JUMP | (BEQ & ZERO) | (BNE & ~ZERO);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StInit;
      pc_q          <= RESET_PC;
      tgt_q         <= '0;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          state_q       <= StRun;
          fetch_valid_q <= 1'b1;
        end
        StRun: begin
          if (!STALL) begin
            if (!taken) begin
              pc_q <= pc_seq;
            end else if (REDIRECT_LAT == 1) begin
              pc_q <= target;
            end else begin
              tgt_q         <= target;
              cnt_q         <= CNT_LOAD;
              state_q       <= StWait;
              fetch_valid_q <= 1'b0;
              busy_q        <= 1'b1;
            end
          end
        end
        StWait: begin
          // Inputs are ignored here; the countdown never pauses.
          if (cnt_q == '0) begin
            pc_q          <= tgt_q;
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign PC            = pc_q;
  assign PC_SEQ        = pc_seq;
  assign FETCH_VALID   = fetch_valid_q;
  assign REDIRECT_BUSY = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances (latency 1, 2, 3) share stimulus.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall, jump, beq, bne, zero;
  logic [7:0] offset;

  logic [31:0] pc1, seq1, pc2, seq2, pc3, seq3;
  logic        fv1, bz1, fv2, bz2, fv3, bz3;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.REDIRECT_LAT(1), .RESET_PC(32'hFFFF_FFFC)) d1 (
    .CLK(clk), .RESET_N(rst_n), .STALL(stall), .JUMP(jump), .BEQ(beq), .BNE(bne),
    .ZERO(zero), .OFFSET(offset), .PC(pc1), .PC_SEQ(seq1), .FETCH_VALID(fv1),
    .REDIRECT_BUSY(bz1)
  );

  pc_sequencer d2 (
    .CLK(clk), .RESET_N(rst_n), .STALL(stall), .JUMP(jump), .BEQ(beq), .BNE(bne),
    .ZERO(zero), .OFFSET(offset), .PC(pc2), .PC_SEQ(seq2), .FETCH_VALID(fv2),
    .REDIRECT_BUSY(bz2)
  );

  pc_sequencer #(.REDIRECT_LAT(3)) d3 (
    .CLK(clk), .RESET_N(rst_n), .STALL(stall), .JUMP(jump), .BEQ(beq), .BNE(bne),
    .ZERO(zero), .OFFSET(offset), .PC(pc3), .PC_SEQ(seq3), .FETCH_VALID(fv3),
    .REDIRECT_BUSY(bz3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; jump = 0; beq = 0; bne = 0; zero = 0; offset = 8'h00;
  endtask

  // Reset across one edge, release, then take the INIT edge.
  task automatic reset_and_init();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc2", pc2, 32'h0);
    chk("rst_fv2", {31'b0, fv2}, 32'h0);
    chk("rst_bz2", {31'b0, bz2}, 32'h0);
    chk("rst_pc1", pc1, 32'hFFFF_FFFC);
    step();
    chk("rst_hold_pc2", pc2, 32'h0);
    rst_n = 1'b1;

    // INIT edge keeps PC, then sequential stepping.
    step();
    chk("init_pc", pc2, 32'h0);
    chk("init_fv", {31'b0, fv2}, 32'h1);
    chk("init_seq", seq2, 32'h4);
    step(); chk("seq_4", pc2, 32'h4);
    step(); chk("seq_8", pc2, 32'h8);
    step(); chk("seq_c", pc2, 32'hC);
    for (int i = 0; i < 5; i++) step();
    chk("seq_20", pc2, 32'h20);

    // BEQ taken with negative offset, latency 2.
    beq = 1; zero = 1; offset = 8'hFE;
    step();
    clear_inputs();
    chk("beq_busy", {31'b0, bz2}, 32'h1);
    chk("beq_hold_pc", pc2, 32'h20);
    chk("beq_fv_low", {31'b0, fv2}, 32'h0);
    step();
    chk("beq_target", pc2, 32'h1C);
    chk("beq_fv", {31'b0, fv2}, 32'h1);
    chk("beq_busy_clr", {31'b0, bz2}, 32'h0);

    // BNE with ZERO=1 falls through; stall holds PC and ignores a jump.
    reset_and_init();
    for (int i = 0; i < 8; i++) step();
    chk("bne_at_20", pc2, 32'h20);
    bne = 1; zero = 1;
    step();
    clear_inputs();
    chk("bne_not_taken", pc2, 32'h24);
    stall = 1; jump = 1; offset = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc2, 32'h24);
      chk("stall_busy", {31'b0, bz2}, 32'h0);
    end
    clear_inputs();

    // Offset 0 taken still redirects with full latency.
    step();
    chk("pre_jump0", pc2, 32'h28);
    jump = 1; offset = 8'h00;
    step();
    clear_inputs();
    chk("jump0_busy", {31'b0, bz2}, 32'h1);
    chk("jump0_hold", pc2, 32'h28);
    step();
    chk("jump0_target", pc2, 32'h2C);

    // Latency 1: wrap on sequential step, and jump across the wrap.
    reset_and_init();
    chk("lat1_init", pc1, 32'hFFFF_FFFC);
    chk("lat1_seq_wrap", seq1, 32'h0);
    step();
    chk("lat1_step_wrap", pc1, 32'h0);
    reset_and_init();
    jump = 1; offset = 8'h01;
    step();
    clear_inputs();
    chk("lat1_jump_wrap", pc1, 32'h4);
    chk("lat1_busy", {31'b0, bz1}, 32'h0);
    chk("lat1_fv", {31'b0, fv1}, 32'h1);

    // Latency 3: reset during WAIT abandons the redirect.
    reset_and_init();
    jump = 1; offset = 8'h05;
    step();
    clear_inputs();
    chk("lat3_busy", {31'b0, bz3}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("lat3_rst_pc", pc3, 32'h0);
    chk("lat3_rst_busy", {31'b0, bz3}, 32'h0);
    chk("lat3_rst_fv", {31'b0, fv3}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("lat3_reinit", pc3, 32'h0);
    step(); chk("lat3_after_4", pc3, 32'h4);
    step(); chk("lat3_after_8", pc3, 32'h8);
    step(); chk("lat3_after_c", pc3, 32'hC);
    chk("lat3_no_busy", {31'b0, bz3}, 32'h0);

    // Latency 3: request held with a new offset during WAIT is ignored.
    reset_and_init();
    jump = 1; offset = 8'h03;
    step();
    chk("lat3h_busy1", {31'b0, bz3}, 32'h1);
    chk("lat3h_pc1", pc3, 32'h0);
    offset = 8'h07;
    step();
    chk("lat3h_busy2", {31'b0, bz3}, 32'h1);
    chk("lat3h_pc2", pc3, 32'h0);
    step();
    clear_inputs();
    chk("lat3h_target", pc3, 32'h10);
    chk("lat3h_fv", {31'b0, fv3}, 32'h1);
    chk("lat3h_busy_clr", {31'b0, bz3}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of the PC and all address arithmetic.
REQ-002 Parameter OFF_WIDTH, default 8: width of the signed word offset for jumps and branches.
REQ-003 Parameter STEP, default 4: byte increment per sequential fetch; power of two, >=1.
REQ-004 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-005 Parameter REDIRECT_LAT, default 2: clock edges from redirect accept to PC = target; >=1.
REQ-006 The design SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-007 CLK  input  1  rising-edge clock.
REQ-008 RESET_N  input  1  asynchronous active-low reset.
REQ-009 STALL  input  1  hold the PC in RUN.
REQ-010 JUMP  input  1  unconditional redirect request.
REQ-011 BEQ  input  1  branch if ZERO=1.
REQ-012 BNE  input  1  branch if ZERO=0.
REQ-013 ZERO  input  1  ALU zero flag.
REQ-014 OFFSET  input  OFF_WIDTH  signed word offset.
REQ-015 PC  output  PC_WIDTH  current fetch address, registered.
REQ-016 PC_SEQ  output  PC_WIDTH  PC+STEP, combinational.
REQ-017 FETCH_VALID  output  1  PC is a valid fetch address this cycle, registered.
REQ-018 REDIRECT_BUSY  output  1  redirect in flight (state WAIT), registered.

Function
REQ-019 States SHALL be INIT, RUN, WAIT; INIT -> RUN on the first edge after reset release, PC unchanged, FETCH_VALID becomes 1.
REQ-020 Taken SHALL be JUMP | (BEQ & ZERO) | (BNE & ~ZERO), sampled only in RUN with STALL=0.
REQ-021 Target SHALL be PC_SEQ + (sign-extended OFFSET shifted left by log2(STEP)), computed from the PC value at the accept edge.
REQ-022 All PC arithmetic SHALL be modulo 2^PC_WIDTH; wrap past all-ones is silent.
REQ-023 RUN, STALL=1: PC, state and outputs SHALL hold; control inputs are ignored.
REQ-024 RUN, STALL=0, not taken: PC <= PC+STEP at the edge.
REQ-025 RUN, STALL=0, taken, REDIRECT_LAT=1: PC <= target at the same edge; state stays RUN.
REQ-026 RUN, STALL=0, taken, REDIRECT_LAT>1: latch target; load counter with REDIRECT_LAT-2; go to WAIT; PC holds; FETCH_VALID <= 0; REDIRECT_BUSY <= 1.
REQ-027 WAIT: counter decrements each edge; when it is 0, PC <= target, state RUN, FETCH_VALID <= 1, REDIRECT_BUSY <= 0.
REQ-028 In WAIT, STALL, JUMP, BEQ, BNE, ZERO and OFFSET SHALL be ignored; the counter does not pause.
REQ-029 Net latency: PC = target exactly REDIRECT_LAT edges after the accept edge, for every REDIRECT_LAT.
REQ-030 Multiple requests asserted together SHALL resolve to a single redirect, since all share one target.
REQ-031 OFFSET=0 taken SHALL still redirect, to PC_SEQ, with full latency.

Reset
REQ-032 While RESET_N=0, regardless of CLK: PC=RESET_PC, state INIT, FETCH_VALID=0, REDIRECT_BUSY=0, counter=0, latched target=0.
REQ-033 Reset asserted in WAIT SHALL abandon the pending redirect; after release, fetch resumes from RESET_PC via INIT.
REQ-034 Reset release SHALL be applied synchronously to CLK by the environment; no internal synchronizer.

Verification
REQ-035 Reset then 4 idle edges, defaults -> PC 0, 0, 4, 8, 12 (INIT edge first); FETCH_VALID 0 then 1.
REQ-036 PC=0x20, BEQ=1, ZERO=1, OFFSET=0xFE, REDIRECT_LAT=2 -> REDIRECT_BUSY=1 and PC=0x20 for one cycle, then PC=0x1C and FETCH_VALID=1.
REQ-037 PC=0x20, BNE=1, ZERO=1 -> no redirect; PC=0x24. Then STALL=1 for 3 edges -> PC stays 0x24.
REQ-038 PC=0xFFFFFFFC, JUMP=1, OFFSET=0x01, REDIRECT_LAT=1 -> PC=0x00000004 next edge. Separately, sequential step from 0xFFFFFFFC -> 0x00000000.
REQ-039 REDIRECT_LAT=3, JUMP accepted, RESET_N low one edge later -> PC=RESET_PC, REDIRECT_BUSY=0, no later jump to target.
REQ-040 REDIRECT_LAT=3, JUMP accepted, JUMP held with new OFFSET during WAIT -> PC reaches the first target after exactly 3 edges; the second request is ignored.
